// File: rtl/seven_seg_scanner_if.sv
// Display-code and panel-pin bundle between display selection, the scanner and the pins.
// The blink bus exists only when SEG_BLINK_EN is defined.
interface seven_seg_scanner_if;
  logic [7:0] disp0;
  logic [7:0] disp1;
  logic [7:0] disp2;
  logic [7:0] disp3;
`ifdef SEG_BLINK_EN
  logic [3:0] blink;
`endif
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

`ifdef SEG_BLINK_EN
  modport master (output disp0, disp1, disp2, disp3, blink, input an, seg, dp);
  modport slave  (input disp0, disp1, disp2, disp3, blink, output an, seg, dp);
`else
  modport master (output disp0, disp1, disp2, disp3, input an, seg, dp);
  modport slave  (input disp0, disp1, disp2, disp3, output an, seg, dp);
`endif
endinterface

// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode 7-segment scanner: per-frame snapshot, anti-ghost blanking, hex/dash decode.
// Optional per-digit blink enabled by defining SEG_BLINK_EN.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  seven_seg_scanner_if.slave  bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0] CODE_OFF  = 8'h10;
  localparam logic [7:0] CODE_DASH = 8'h11;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [3:0][7:0]  frame_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic       slot_wrap;
  logic       frame_start;
  logic [7:0] code_c;
  logic       blanked_c;
  logic [3:0] an_d;
  logic [6:0] seg_d;

  function automatic logic [6:0] decode(input logic [7:0] code);
    logic [6:0] s;
    s = 7'h7F;
    if (code[7:4] == 4'h0) begin
      case (code[3:0])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b0000011;
        4'hC: s = 7'b1000110;
        4'hD: s = 7'b0100001;
        4'hE: s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end else if (code == CODE_DASH) begin
      s = 7'b0111111;
    end
    return s;
  endfunction

  assign slot_wrap   = (cnt_q == CNT_MAX);
  // First cycle of digit 0: the frame is captured here, and decode looks through to the live input.
  assign frame_start = (cnt_q == '0) && (idx_q == 2'd0);

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_wrap) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Frame snapshot; holds for the whole frame so mid-frame input changes never tear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= {4{CODE_OFF}};
    end else if (frame_start) begin
      frame_q <= {bus.disp3, bus.disp2, bus.disp1, bus.disp0};
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0] fcnt_q;
  logic              phase_q;
  logic [3:0]        blink_q;
  logic              frame_wrap;
  logic              blink_c;

  assign frame_wrap = slot_wrap && (idx_q == 2'd3);

  // Frame counter and blink phase; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (frame_wrap) begin
      if (fcnt_q == FCNT_MAX) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= '0;
    end else if (frame_start) begin
      blink_q <= bus.blink;
    end
  end

  assign blink_c = frame_start ? bus.blink[0] : blink_q[idx_q];
`endif

  // Next pin values from the current slot state.
  always_comb begin
    code_c    = frame_start ? bus.disp0 : frame_q[idx_q];
    blanked_c = (32'(cnt_q) < BLANK_CYC);
`ifdef SEG_BLINK_EN
    if (phase_q && blink_c) begin
      blanked_c = 1'b1;
    end
`endif
    an_d  = blanked_c ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = decode(code_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= 1'b1;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
